// File: rtl/arbitro_barramento.sv
// Snoop-bus arbiter and phase sequencer (write-back, broadcast, memory wait) for the MSI system.
// Optional macro ARB_FIXED_PRIORITY_EN selects fixed lowest-index priority instead of round-robin.
module arbitro_barramento #(
  parameter int N_CPU     = 4,
  parameter int WB_CYCLES = 2,
  parameter int MEM_LAT   = 3
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic [N_CPU-1:0]           req,
  input  logic [2*N_CPU-1:0]         req_bus,
  input  logic [N_CPU-1:0]           req_wb,
  output logic [N_CPU-1:0]           grant,
  output logic [$clog2(N_CPU)-1:0]   bus_owner,
  output logic [1:0]                 bus_op,
  output logic                       bus_valid,
  output logic                       wb_active,
  output logic [N_CPU-1:0]           done,
  output logic                       busy
);

  localparam int IW   = $clog2(N_CPU);
  localparam int MAXC = (WB_CYCLES > MEM_LAT) ? WB_CYCLES : MEM_LAT;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_GRANT = 3'd1,
    S_WB    = 3'd2,
    S_BCAST = 3'd3,
    S_MEM   = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t            r_state;
  logic [CW-1:0]     r_cnt;
  logic [IW-1:0]     r_owner;
  logic [1:0]        r_op;
  logic              r_wb;
  logic [N_CPU-1:0]  r_grant;
  logic [1:0]        r_bus_op;
  logic              r_bus_valid;
  logic              r_wb_active;
  logic [N_CPU-1:0]  r_done;
  logic              r_busy;
`ifdef ARB_FIXED_PRIORITY_EN
`else
  logic [IW-1:0]     r_rr;
`endif

  logic [N_CPU-1:0]  w_cand;
  logic              w_any;
  logic [IW-1:0]     w_winner;
  logic [1:0]        w_op;
  logic              w_wb;

  function automatic logic [N_CPU-1:0] onehot(input logic [IW-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

  // First set bit of v, scanning upward from base and wrapping; base=0 gives fixed priority.
  function automatic logic [IW-1:0] rr_pick(input logic [N_CPU-1:0] v, input logic [IW-1:0] base);
    int idx;
    rr_pick = '0;
    for (int k = N_CPU - 1; k >= 0; k--) begin
      idx = (int'(base) + k) % N_CPU;
      if (v[IW'(idx)]) begin
        rr_pick = IW'(idx);
      end
    end
  endfunction

  // Candidate filtering and winner selection for the IDLE arbitration.
  always_comb begin
    for (int i = 0; i < N_CPU; i++) begin
      w_cand[i] = req[i] & (req_bus[2*i +: 2] != 2'b00);
    end
    w_any = |w_cand;
`ifdef ARB_FIXED_PRIORITY_EN
    w_winner = rr_pick(w_cand, {IW{1'b0}});
`else
    w_winner = rr_pick(w_cand, r_rr);
`endif
    w_op = req_bus[{w_winner, 1'b0} +: 2];
    w_wb = req_wb[w_winner];
  end

  // Transaction FSM with all bus-facing outputs registered alongside the state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_owner     <= '0;
      r_op        <= 2'b00;
      r_wb        <= 1'b0;
      r_grant     <= '0;
      r_bus_op    <= 2'b00;
      r_bus_valid <= 1'b0;
      r_wb_active <= 1'b0;
      r_done      <= '0;
      r_busy      <= 1'b0;
`ifdef ARB_FIXED_PRIORITY_EN
`else
      r_rr        <= '0;
`endif
    end else begin
      r_done      <= '0;
      r_bus_valid <= 1'b0;
      r_bus_op    <= 2'b00;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_owner <= w_winner;
            r_op    <= w_op;
            r_wb    <= w_wb;
            r_grant <= onehot(w_winner);
            r_busy  <= 1'b1;
            r_state <= S_GRANT;
          end else begin
            r_grant <= '0;
            r_busy  <= 1'b0;
          end
        end
        S_GRANT: begin
          if (r_wb) begin
            r_cnt       <= CW'(WB_CYCLES - 1);
            r_wb_active <= 1'b1;
            r_state     <= S_WB;
          end else begin
            r_bus_valid <= 1'b1;
            r_bus_op    <= r_op;
            r_state     <= S_BCAST;
          end
        end
        S_WB: begin
          if (r_cnt == {CW{1'b0}}) begin
            r_wb_active <= 1'b0;
            r_bus_valid <= 1'b1;
            r_bus_op    <= r_op;
            r_state     <= S_BCAST;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_BCAST: begin
          // Invalidates need no data, so they skip the memory wait.
          if (r_op == 2'b11) begin
            r_done  <= onehot(r_owner);
            r_state <= S_DONE;
          end else begin
            r_cnt   <= CW'(MEM_LAT - 1);
            r_state <= S_MEM;
          end
        end
        S_MEM: begin
          if (r_cnt == {CW{1'b0}}) begin
            r_done  <= onehot(r_owner);
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_DONE: begin
          r_grant <= '0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
`ifdef ARB_FIXED_PRIORITY_EN
`else
          r_rr    <= (r_owner == IW'(N_CPU - 1)) ? {IW{1'b0}} : r_owner + 1'b1;
`endif
        end
        default: begin
          r_grant     <= '0;
          r_busy      <= 1'b0;
          r_wb_active <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign grant     = r_grant;
  assign bus_owner = r_owner;
  assign bus_op    = r_bus_op;
  assign bus_valid = r_bus_valid;
  assign wb_active = r_wb_active;
  assign done      = r_done;
  assign busy      = r_busy;

endmodule

// File: tb/tb_arbitro_barramento.sv
// Randomized and directed bench for arbitro_barramento against a transaction-timeline reference model.
module tb_arbitro_barramento;

  localparam int N  = 4;
  localparam int WB = 2;
  localparam int ML = 3;

  logic             clock = 1'b0;
  logic             reset_n;
  logic [N-1:0]     req;
  logic [2*N-1:0]   req_bus;
  logic [N-1:0]     req_wb;
  logic [N-1:0]     grant;
  logic [1:0]       bus_owner;
  logic [1:0]       bus_op;
  logic             bus_valid;
  logic             wb_active;
  logic [N-1:0]     done;
  logic             busy;

  int n_err = 0;
  int n_chk = 0;

  // Reference model: one transaction described by its start and phase offsets.
  bit m_active;
  int m_rel, m_owner, m_op, m_wb, m_bc_rel, m_done_rel, m_rr;

  arbitro_barramento #(.N_CPU(N), .WB_CYCLES(WB), .MEM_LAT(ML)) dut (
    .clock(clock), .reset_n(reset_n), .req(req), .req_bus(req_bus), .req_wb(req_wb),
    .grant(grant), .bus_owner(bus_owner), .bus_op(bus_op), .bus_valid(bus_valid),
    .wb_active(wb_active), .done(done), .busy(busy)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int pick_winner();
    int w = -1;
`ifdef ARB_FIXED_PRIORITY_EN
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i] && req_bus[2*i +: 2] != 2'b00) w = i;
    end
`else
    for (int k = N - 1; k >= 0; k--) begin
      int i;
      i = (m_rr + k) % N;
      if (req[i] && req_bus[2*i +: 2] != 2'b00) w = i;
    end
`endif
    return w;
  endfunction

  task automatic model_reset();
    m_active = 1'b0;
    m_rel = 0; m_owner = 0; m_op = 0; m_wb = 0; m_bc_rel = 0; m_done_rel = 0; m_rr = 0;
  endtask

  task automatic model_edge();
    int w;
    if (!m_active) begin
      w = pick_winner();
      if (w >= 0) begin
        m_active   = 1'b1;
        m_rel      = 0;
        m_owner    = w;
        m_op       = req_bus[2*w +: 2];
        m_wb       = req_wb[w];
        m_bc_rel   = 1 + (m_wb != 0 ? WB : 0);
        m_done_rel = m_bc_rel + 1 + (m_op != 3 ? ML : 0);
      end
    end else if (m_rel == m_done_rel) begin
      m_active = 1'b0;
`ifndef ARB_FIXED_PRIORITY_EN
      m_rr = (m_owner + 1) % N;
`endif
    end else begin
      m_rel++;
    end
  endtask

  task automatic check_outputs();
    logic [N-1:0] eg, ed;
    bit ev;
    eg = '0; ed = '0;
    if (m_active) eg[m_owner] = 1'b1;
    if (m_active && m_rel == m_done_rel) ed[m_owner] = 1'b1;
    ev = m_active && (m_rel == m_bc_rel);
    chk_val("grant", grant, eg);
    chk_val("busy", busy, m_active);
    chk_val("bus_valid", bus_valid, ev);
    chk_val("bus_op", bus_op, ev ? m_op : 0);
    chk_val("wb_active", wb_active, m_active && m_wb != 0 && m_rel >= 1 && m_rel <= WB);
    chk_val("done", done, ed);
    if (m_active) chk_val("bus_owner", bus_owner, m_owner);
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic wait_idle();
    req = '0;
    for (int k = 0; k < 30 && m_active; k++) step();
    step();
    chk_val("idle_reached", m_active, 0);
  endtask

  task automatic run_single(input string tag, input int cpu, input logic [1:0] code, input logic wb,
                            input int drop_k, input int exp_bc, input int exp_dc, input int exp_wbn);
    int bc = 0, dc = 0, wbn = 0;
    req = '0; req_bus = '0; req_wb = '0;
    req[cpu] = 1'b1;
    req_bus[2*cpu +: 2] = code;
    req_wb[cpu] = wb;
    for (int k = 1; k <= 20 && dc == 0; k++) begin
      step();
      if (bus_valid && bc == 0) bc = k;
      if (wb_active) wbn++;
      if (done[cpu]) begin
        dc = k;
        req = '0;
      end
      if (k == drop_k) req[cpu] = 1'b0;
    end
    step();
    chk_val({tag, "_bcast_cycle"}, bc, exp_bc);
    chk_val({tag, "_done_cycle"}, dc, exp_dc);
    chk_val({tag, "_wb_cycles"}, wbn, exp_wbn);
    chk_val({tag, "_idle_after"}, busy, 0);
  endtask

  initial begin
    int got[5];
    int ng, nbusy;
    logic [N-1:0] prev;

    reset_n = 1'b0; req = '0; req_bus = '0; req_wb = '0;
    model_reset();
    #12;
    chk_val("rst_grant", grant, 0);
    chk_val("rst_owner", bus_owner, 0);
    chk_val("rst_op", bus_op, 0);
    chk_val("rst_valid", bus_valid, 0);
    chk_val("rst_wb", wb_active, 0);
    chk_val("rst_done", done, 0);
    chk_val("rst_busy", busy, 0);
    @(negedge clock);
    reset_n = 1'b1;
    step();

    // All CPUs hold read misses continuously.
    req = '1;
    for (int i = 0; i < N; i++) req_bus[2*i +: 2] = 2'b01;
    req_wb = '0;
    ng = 0; prev = '0;
    for (int k = 0; k < 80 && ng < 5; k++) begin
      step();
      if (grant != '0 && prev == '0) begin
        got[ng] = bus_owner;
        ng++;
      end
      prev = grant;
    end
    chk_val("rr_grants", ng, 5);
`ifdef ARB_FIXED_PRIORITY_EN
    for (int i = 0; i < 5; i++) chk_val("fixed_order", got[i], 0);
`else
    for (int i = 0; i < 5; i++) chk_val("rr_order", got[i], i % N);
`endif
    wait_idle();

    run_single("rd_miss", 1, 2'b01, 1'b0, 0, 2, 6, 0);
    run_single("wr_miss_wb", 2, 2'b10, 1'b1, 0, 4, 8, 2);
    run_single("inval", 0, 2'b11, 1'b0, 0, 2, 3, 0);
    run_single("drop_in_mem", 1, 2'b01, 1'b0, 3, 2, 6, 0);

    // Code 00 must never be granted.
    req = '0; req_bus = '0; req[3] = 1'b1;
    nbusy = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (busy) nbusy++;
    end
    chk_val("code00_busy_cycles", nbusy, 0);

    // Reset mid-MEM while another CPU is waiting; rr restarts at 0.
    req = '0; req_bus = '0; req_wb = '0;
    req[1] = 1'b1; req_bus[3:2] = 2'b01;
    for (int k = 0; k < 4; k++) begin
      step();
      req[3] = 1'b1; req_bus[7:6] = 2'b01;
    end
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    chk_val("arst_grant", grant, 0);
    chk_val("arst_busy", busy, 0);
    chk_val("arst_done", done, 0);
    chk_val("arst_valid", bus_valid, 0);
    chk_val("arst_op", bus_op, 0);
    chk_val("arst_owner", bus_owner, 0);
    @(negedge clock);
    reset_n = 1'b1;
    step();
`ifdef ARB_FIXED_PRIORITY_EN
    chk_val("post_reset_grant", grant, 4'b0010);
`else
    chk_val("post_reset_grant", grant, 4'b0010);
`endif

    // Random requesters, including code 00, drops and post-latch changes.
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++) begin
        if (done[i]) begin
          req[i] = 1'b0;
        end else if (!req[i] && $urandom_range(0, 3) == 0) begin
          req[i] = 1'b1;
          req_bus[2*i +: 2] = 2'($urandom_range(0, 3));
          req_wb[i] = 1'($urandom_range(0, 1));
        end else if ($urandom_range(0, 31) == 0) begin
          req[i] = 1'b0;
        end else if ($urandom_range(0, 15) == 0) begin
          req_bus[2*i +: 2] = 2'($urandom_range(0, 3));
          req_wb[i] = 1'($urandom_range(0, 1));
        end
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/arbitro_barramento.md
# arbitro_barramento

Snooping-bus arbiter and transaction sequencer for the MSI coherence system. It sits between the per-CPU coherence state machines and the shared snoop bus. It collects bus requests (read miss 01, write miss 10, invalidate 11), each with an optional write-back flag. It grants the bus to one CPU at a time, round-robin, and sequences the phases: write-back, broadcast, then memory wait. It pulses completion back to the owner.

## Interface
Parameters:
- `N_CPU`, 4: number of requesters; 2..8.
- `WB_CYCLES`, 2: cycles the write-back phase occupies; ≥1.
- `MEM_LAT`, 3: memory-response wait after a read or write miss broadcast; ≥1.

Ports:
- `clock` in 1: single clock; all state on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `req` in N_CPU: per-CPU bus request level.
- `req_bus` in 2·N_CPU: per-CPU bus code. CPU i uses bits [2i+1:2i]. 00 = none, 01 = read miss, 10 = write miss, 11 = invalidate.
- `req_wb` in N_CPU: per-CPU write-back-required flag (Modified-block eviction).
- `grant` out N_CPU: one-hot registered grant.
- `bus_owner` out clog2(N_CPU): index of the current owner.
- `bus_op` out 2: code driven on the snoop bus; 00 outside the broadcast phase.
- `bus_valid` out 1: broadcast strobe; snoopers sample `bus_op`/`bus_owner` in this cycle.
- `wb_active` out 1: high during the write-back phase.
- `done` out N_CPU: one-cycle completion pulse to the owner.
- `busy` out 1: high in every state except IDLE.

## Operation
- A CPU counts as a candidate only when `req[i]`=1 and its `req_bus` code is ≠00. A request with code 00 is ignored.
- Arbitration is round-robin. The search starts at pointer `rr` and wraps modulo N_CPU; the first candidate wins. In DONE, `rr` is set to owner+1, modulo N_CPU.
- States:
  - IDLE: if any candidate exists, latch the winner index, the op, and the `req_wb` bit, then go to GRANT. Otherwise stay in IDLE.
  - GRANT: go to WB if the latched wb bit is 1, else go to BCAST.
  - WB: `wb_active`=1 for exactly WB_CYCLES cycles, then go to BCAST.
  - BCAST: `bus_valid`=1 and `bus_op`=latched op for one cycle. If the op is 01 or 10, go to MEM; if the op is 11, go to DONE.
  - MEM: stay for exactly MEM_LAT cycles, then go to DONE.
  - DONE: `done[owner]`=1 for one cycle, update `rr`, go to IDLE.
- `grant[owner]` is high from the GRANT cycle through the DONE cycle inclusive. It is low in IDLE.
- Op and wb are latched once per transaction. Changes to `req`, `req_bus` or `req_wb` after latching have no effect, and a dropped `req` does not abort the transaction.
- Requesters hold `req` until they see `done`. A request still high in the IDLE cycle after DONE re-arbitrates normally.
- A request arriving while the arbiter is busy waits; it cannot preempt the current transaction.
- The wait counter is wide enough for max(WB_CYCLES, MEM_LAT). It reloads on every phase entry.

## Timing
- Reset state:
  - `grant`=0, `bus_owner`=0, `bus_op`=00, `bus_valid`=0, `wb_active`=0, `done`=0, `busy`=0.
  - state=IDLE, `rr`=0, counter=0.
- Reset is asynchronous. Asserting `reset_n` mid-transaction forces the reset state immediately; no `done` pulse is issued for the aborted transaction.
- All outputs are registered, decoded from the state and latched values.
- Latency, with the request sampled at edge 0:
  - grant appears in cycle 1.
  - BCAST falls in cycle 2 + (wb ? WB_CYCLES : 0).
  - DONE falls in the BCAST cycle + 1 + (op≠11 ? MEM_LAT : 0).
- Default parameters:
  - Read miss without write-back: DONE in cycle 6.
  - Invalidate: DONE in cycle 3.
  - Write miss with write-back: DONE in cycle 8.
- Minimum spacing between two back-to-back transactions is one IDLE cycle: DONE → IDLE → GRANT.

## Configuration
- `ARB_FIXED_PRIORITY_EN`:
  - Defined: fixed priority, the lowest candidate index always wins, and `rr` is neither used nor updated.
  - Undefined (default): round-robin exactly as above.

## Test plan
- Single read miss: CPU1 `req`, code 01, wb=0 → `grant`=0010 in cycles 1–6, `bus_valid` with `bus_op`=01 and `bus_owner`=1 in cycle 2, `done[1]` in cycle 6, `busy`=0 in cycle 7.
- Write miss with write-back: CPU2, code 10, wb=1 → `wb_active` in cycles 2–3, broadcast 10 in cycle 4, `done[2]` in cycle 8.
- Invalidate: CPU0, code 11 → broadcast 11 in cycle 2, `done[0]` in cycle 3, no MEM phase.
- Round-robin: all four CPUs hold read-miss requests continuously → owners granted in order 0, 1, 2, 3, 0; each `done` pulses exactly once per grant. With `ARB_FIXED_PRIORITY_EN` defined → CPU0 wins every arbitration.
- Request hygiene:
  - `req[3]`=1 with code 00 → never granted, `busy` stays 0.
  - Owner drops `req` during MEM → transaction still completes with `done`.
- Reset mid-MEM: pulse `reset_n` low → all outputs 0 asynchronously, no `done`. After release, the pending request is re-granted starting from `rr`=0.
